in_port_unit: RTL and testbench
===============================

# in_port_unit

Input-port capture unit for the pipelined CPU wrapper; the input-side counterpart of the `O_Port` output register. It synchronises the external `I_Port` bus, detects value changes, and buffers each new value in a small FIFO. The CPU's `IN` instruction drains that FIFO, so bursts of port changes between `IN` executions are not lost. An optional interrupt request tells the core that data is waiting.

## Interface
- `WIDTH`, default 8: port and data width.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, ≥2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `I_Port` input WIDTH: external asynchronous input bus.
- `rd_en` input 1: `IN` instruction pop request, one cycle per instruction.
- `rd_data` output WIDTH: registered read data.
- `rd_valid` output 1: `rd_data` is valid this cycle; a one-cycle pulse.
- `empty` output 1: FIFO holds no entries.
- `full` output 1: FIFO holds DEPTH entries.
- `overflow` output 1: sticky flag; a change was dropped because the FIFO was full.
- `clr_ovf` input 1: clears `overflow`.
- `int_req` output 1: data-pending interrupt request (see Configuration).

## Operation
- **Synchroniser**: two flops, `s1` ← `I_Port`, then `s2` ← `s1`. No other logic uses `I_Port` directly.
- **Change detector**: register `last`. When `s2 != last`, assert push and load `last` ← `s2`.
- **Push**: writes `s2` at `wr_ptr`, then increments it. Pointers are log2(DEPTH) bits wide and wrap naturally. `count` is log2(DEPTH)+1 bits wide.
- **Pop**: on `rd_en` with the FIFO non-empty, `rd_data` ← `mem[rd_ptr]`, `rd_ptr` increments, and `rd_valid` = 1 on the next cycle.
- **Pop while empty**: on `rd_en` with `empty`, `rd_data` ← `s2` (the live port value) and `rd_valid` = 1. Pointers and `count` are unchanged. An `IN` instruction therefore never stalls.
- **Push while full, no pop**: the value is dropped, `overflow` ← 1, and `last` still updates. The FIFO contents are unchanged.
- **Push and pop in the same cycle while full**: both are performed and `count` stays at DEPTH. `overflow` is not set.
- **Push and pop in the same cycle while empty**: the pop returns `s2` (the live path) and the push still enqueues, so `count` becomes 1. The same value is read twice; this is intentional.
- **Overflow flag**: `clr_ovf` clears it. If `clr_ovf` and a new overflow event occur in the same cycle, set wins.
- **Flags**: `empty` = (`count`==0) and `full` = (`count`==DEPTH), both decoded from registered `count`.
- **Reset**: `s1`, `s2`, `last`, `rd_data`, pointers and `count` all go to 0. `rd_valid`, `overflow` and `int_req` go to 0, `empty` = 1 and `full` = 0. A reset mid-operation flushes all buffered data. Because `last` resets to 0, a non-zero `I_Port` held through reset produces exactly one push after release.

## Timing
- Capture latency: `I_Port` stable before edge k gives `s1` at k, `s2` at k+1, and the push at k+2. `empty` falls after edge k+2.
- Read latency: `rd_en` sampled at edge n gives `rd_data`/`rd_valid` valid from edge n through edge n+1.
- `int_req` is registered: it follows `!empty` one cycle later.
- Changes are captured at most once per cycle. A glitch shorter than one clock period may be missed; this is acceptable.
- Back-to-back `rd_en` on consecutive cycles is legal and each is serviced.

## Configuration
- Macro: `IN_PORT_INT_EN`.
- **Defined**: `int_req` is a registered copy of `!empty`. It asserts one cycle after the first push and deasserts one cycle after the pop that empties the FIFO.
- **Undefined**: `int_req` is tied to 0 and its register is not built. All other behaviour is identical.

## Test plan
- **Reset and pass-through**: hold `rst` with `I_Port`=0, release, then pulse `rd_en` with the FIFO empty → `rd_valid`=1, `rd_data`=0x00, `empty` stays 1.
- **Single capture**: set `I_Port`=0x55 → `empty` falls 3 edges later and, with `IN_PORT_INT_EN`, `int_req` rises 1 cycle after that. Then `rd_en` → `rd_data`=0x55, `empty`=1, and `int_req` falls.
- **Burst and order**: change `I_Port` to 0x11, 0x22, 0x33, 0x44, one value every 3 cycles → `full`=1. Four `rd_en` pulses → 0x11, 0x22, 0x33, 0x44 in order.
- **Overflow**: with the FIFO full, apply `I_Port`=0x99 → `overflow`=1 and the contents remain 0x11..0x44. Then `clr_ovf` → `overflow`=0.
- **Simultaneous push and pop while full**: a new value 0xAA arrives in the same cycle as `rd_en` → `rd_data`=0x11, `count` stays 4, `overflow` stays 0, and the last entry read is 0xAA.
- **Reset mid-burst**: assert `rst` with 3 entries buffered → `empty`=1 and `rd_valid`=0. The next read returns the live `s2` value.

Source files
------------

// File: rtl/in_port_if.sv
// Input-port unit bus: external port, IN-instruction pop handshake and status.
//   slave  : used by in_port_unit (receives I_Port/rd_en/clr_ovf, drives data/status)
//   master : used by the CPU-side driver (the reverse directions)
interface in_port_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] I_Port;
    logic             rd_en;
    logic             clr_ovf;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             int_req;

    modport slave (
        input  I_Port, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, overflow, int_req
    );

    modport master (
        output I_Port, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, overflow, int_req
    );
endinterface

// File: rtl/in_port_unit.sv
// Input-port capture unit: synchronises I_Port, pushes each changed value into
// a DEPTH-entry FIFO, and serves IN-instruction pops (live port value when empty).
// Ports: clk, rst (sync, active-high), bus (in_port_if.slave):
//   I_Port, rd_en, clr_ovf in; rd_data, rd_valid, empty, full, overflow, int_req out.
// Option macro IN_PORT_INT_EN: builds the registered data-pending int_req;
// without it int_req is tied low.
module in_port_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    in_port_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic empty_c, full_c, push_c, pop_c, wr_en_c;

    assign empty_c = (count_q == CW'(0));
    assign full_c  = (count_q == CW'(DEPTH));

    // Next-state: sync chain, change detect, FIFO pointers/count, read port, overflow
    always_comb begin
        s1_d       = bus.I_Port;
        s2_d       = s1_q;
        last_d     = s2_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = bus.rd_en;
        overflow_d = overflow_q;

        push_c  = (s2_q != last_q);
        pop_c   = bus.rd_en && !empty_c;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept
        wr_en_c = push_c && (!full_c || pop_c);

        if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c)   rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(wr_en_c) - CW'(pop_c);

        // Empty FIFO: return the live synchronised value so IN never stalls
        if (bus.rd_en) rd_data_d = empty_c ? s2_q : mem_q[rd_ptr_q];

        // New overflow event beats a simultaneous clear
        if (push_c && !wr_en_c) overflow_d = 1'b1;
        else if (bus.clr_ovf)   overflow_d = 1'b0;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care while count is 0
    always_ff @(posedge clk) begin
        if (wr_en_c && !rst) mem_q[wr_ptr_q] <= s2_q;
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_c;
    assign bus.full     = full_c;
    assign bus.overflow = overflow_q;

`ifdef IN_PORT_INT_EN
    logic int_req_q, int_req_d;

    // Data-pending request trails the empty flag by one cycle
    always_comb begin
        int_req_d = !empty_c;
    end

    always_ff @(posedge clk) begin
        if (rst) int_req_q <= 1'b0;
        else     int_req_q <= int_req_d;
    end

    assign bus.int_req = int_req_q;
`else
    assign bus.int_req = 1'b0;
`endif

endmodule

// File: tb/tb_in_port_unit.sv
// Self-checking bench for in_port_unit: directed table, corner-case sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_in_port_unit;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    in_port_if #(.WIDTH(WIDTH)) bus ();

    in_port_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [WIDTH-1:0] m_s1, m_s2, m_last, m_rd_data;
    logic             m_rd_valid, m_ovf, m_int;
    logic [WIDTH-1:0] m_q [$];

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock edge of the behavioural model, using the inputs held across the edge
    task automatic model_step();
        int  n;
        bit  pop, push, ovf_ev;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_last = '0; m_rd_data = '0;
            m_rd_valid = 1'b0; m_ovf = 1'b0; m_int = 1'b0;
            m_q.delete();
            return;
        end
        n      = m_q.size();
        pop    = bus.rd_en && (n != 0);
        push   = (m_s2 != m_last);
        ovf_ev = 1'b0;
        m_rd_valid = bus.rd_en;
        if (bus.rd_en) m_rd_data = (n == 0) ? m_s2 : m_q[0];
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (n < DEPTH || pop) m_q.push_back(m_s2);
            else ovf_ev = 1'b1;
        end
        if (ovf_ev) m_ovf = 1'b1;
        else if (bus.clr_ovf) m_ovf = 1'b0;
`ifdef IN_PORT_INT_EN
        m_int = (n != 0);
`else
        m_int = 1'b0;
`endif
        m_last = m_s2;
        m_s2   = m_s1;
        m_s1   = bus.I_Port;
    endtask

    task automatic cmp_model();
        chk("rd_valid", int'(bus.rd_valid), int'(m_rd_valid));
        chk("rd_data",  int'(bus.rd_data),  int'(m_rd_data));
        chk("empty",    int'(bus.empty),    int'(m_q.size() == 0));
        chk("full",     int'(bus.full),     int'(m_q.size() == DEPTH));
        chk("overflow", int'(bus.overflow), int'(m_ovf));
        chk("int_req",  int'(bus.int_req),  int'(m_int));
    endtask

    // Advance one cycle and sample #1 after the edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic hold(input logic [WIDTH-1:0] v, input int n);
        bus.I_Port = v;
        bus.rd_en  = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic rd1(input string name, input logic [WIDTH-1:0] exp);
        bus.rd_en = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
        chk({name, "_valid"}, int'(bus.rd_valid), 1);
        chk(name, int'(bus.rd_data), int'(exp));
    endtask

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] ip;
        logic             rd;
        logic             clr;
        logic             e_empty;
        logic             e_full;
        logic             e_ovf;
        logic             e_rdv;
        logic             e_int;
        logic [WIDTH-1:0] e_data;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int exp_int;
        logic [WIDTH-1:0] ip;

        // rst ip rd clr | empty full ovf rdv int(enabled) data
        tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[7] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55};
        tbl[8] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};

        rst = 1'b1;
        bus.I_Port = '0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
        m_s1 = '0; m_s2 = '0; m_last = '0; m_rd_data = '0;
        m_rd_valid = 1'b0; m_ovf = 1'b0; m_int = 1'b0;

        // Reset, pass-through read and single capture
        for (int i = 0; i < 9; i++) begin
            rst         = tbl[i].rst;
            bus.I_Port  = tbl[i].ip;
            bus.rd_en   = tbl[i].rd;
            bus.clr_ovf = tbl[i].clr;
            cyc();
`ifdef IN_PORT_INT_EN
            exp_int = int'(tbl[i].e_int);
`else
            exp_int = 0;
`endif
            chk($sformatf("tbl%0d_empty", i), int'(bus.empty),    int'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_full", i),  int'(bus.full),     int'(tbl[i].e_full));
            chk($sformatf("tbl%0d_ovf", i),   int'(bus.overflow), int'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_rdv", i),   int'(bus.rd_valid), int'(tbl[i].e_rdv));
            chk($sformatf("tbl%0d_data", i),  int'(bus.rd_data),  int'(tbl[i].e_data));
            chk($sformatf("tbl%0d_int", i),   int'(bus.int_req),  exp_int);
        end
        bus.rd_en = 1'b0;

        // Burst fills the FIFO, drained in order
        hold(8'h11, 3); hold(8'h22, 3); hold(8'h33, 3); hold(8'h44, 3);
        chk("burst_full", int'(bus.full), 1);
        rd1("burst_rd0", 8'h11);
        rd1("burst_rd1", 8'h22);
        rd1("burst_rd2", 8'h33);
        rd1("burst_rd3", 8'h44);
        chk("burst_empty", int'(bus.empty), 1);

        // Overflow on full, then clear
        hold(8'h11, 3); hold(8'h22, 3); hold(8'h33, 3); hold(8'h44, 3);
        hold(8'h99, 3);
        chk("ovf_set", int'(bus.overflow), 1);
        chk("ovf_full", int'(bus.full), 1);
        bus.clr_ovf = 1'b1;
        cyc();
        bus.clr_ovf = 1'b0;
        chk("ovf_clr", int'(bus.overflow), 0);

        // Push and pop in the same cycle while full
        bus.I_Port = 8'hAA;
        cyc(); cyc();
        rd1("pp_full_rd", 8'h11);
        chk("pp_full_full", int'(bus.full), 1);
        chk("pp_full_ovf", int'(bus.overflow), 0);
        rd1("pp_rd1", 8'h22);
        rd1("pp_rd2", 8'h33);
        rd1("pp_rd3", 8'h44);
        rd1("pp_rd4", 8'hAA);
        chk("pp_empty", int'(bus.empty), 1);

        // Reset with three entries buffered, then live read with simultaneous push
        hold(8'h01, 3); hold(8'h02, 3); hold(8'h03, 3);
        chk("mid_not_empty", int'(bus.empty), 0);
        rst = 1'b1;
        cyc(); cyc();
        chk("mid_rst_empty", int'(bus.empty), 1);
        chk("mid_rst_rdv", int'(bus.rd_valid), 0);
        rst = 1'b0;
        cyc(); cyc();
        rd1("mid_live_rd", 8'h03);
        chk("mid_live_pushed", int'(bus.empty), 0);
        rd1("mid_dup_rd", 8'h03);
        chk("mid_dup_empty", int'(bus.empty), 1);

        // Randomized traffic against the model
        ip = 8'h03;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 30) ip = 8'($urandom_range(0, 255));
            bus.I_Port  = ip;
            bus.rd_en   = ($urandom_range(0, 99) < 25);
            bus.clr_ovf = ($urandom_range(0, 99) < 8);
            rst         = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
